// File: rtl/store_write_buffer.sv
// store_write_buffer: store FIFO that issues one outstanding write at a time on the data bus.
// Define STORE_BUF_ALIAS_CHECK_EN for an exact word-address alias check on ld_conflict.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_wstrb,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        buf_empty,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [29:0]    ent_addr [DEPTH];
    logic [31:0]    ent_data [DEPTH];
    logic [3:0]     ent_strb [DEPTH];

    logic [PTR_W:0] wp, rp, wp_next, rp_next, count, count_next;
    logic [1:0]     state, state_next;
    logic           push, pop, full;

    logic [29:0]    head_addr;
    logic [31:0]    head_data;
    logic [3:0]     head_strb;
    logic [2:0]     head_ones;
    logic [1:0]     head_size, head_low2;

    logic           unused_bits;
    assign unused_bits = ^{st_addr[1:0], ld_addr};

    assign count      = wp - rp;
    assign full       = (count == FULL_CNT);
    assign st_ready   = !full;
    assign push       = st_valid && !full;
    assign wp_next    = wp + {{PTR_W{1'b0}}, push};
    assign rp_next    = rp + {{PTR_W{1'b0}}, pop};
    assign count_next = wp_next - rp_next;
    assign buf_empty  = (count == '0) && (state == IDLE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (count != '0) state_next = REQ;
            REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        // Same-cycle completion: chain straight into the next request.
                        pop        = 1'b1;
                        state_next = (count_next != '0) ? REQ : IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            state <= IDLE;
        end else begin
            wp    <= wp_next;
            rp    <= rp_next;
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wp[PTR_W-1:0]] <= st_addr[31:2];
            ent_data[wp[PTR_W-1:0]] <= st_wdata;
            ent_strb[wp[PTR_W-1:0]] <= st_wstrb;
        end
    end

    assign head_addr = ent_addr[rp[PTR_W-1:0]];
    assign head_data = ent_data[rp[PTR_W-1:0]];
    assign head_strb = ent_strb[rp[PTR_W-1:0]];
    assign head_ones = 3'(head_strb[0]) + 3'(head_strb[1]) + 3'(head_strb[2]) + 3'(head_strb[3]);

    always_comb begin
        head_size = (head_ones == 3'd1) ? 2'd0 : (head_ones == 3'd2) ? 2'd1 : 2'd2;
        if (head_strb[0])      head_low2 = 2'd0;
        else if (head_strb[1]) head_low2 = 2'd1;
        else if (head_strb[2]) head_low2 = 2'd2;
        else if (head_strb[3]) head_low2 = 2'd3;
        else                   head_low2 = 2'd0;
    end

    assign data_req   = (state == REQ);
    assign data_wr    = data_req;
    assign data_size  = data_req ? head_size : '0;
    assign data_addr  = data_req ? {head_addr, head_low2} : '0;
    assign data_wstrb = data_req ? head_strb : '0;
    assign data_wdata = data_req ? head_data : '0;

`ifdef STORE_BUF_ALIAS_CHECK_EN
    // The in-flight head stays inside [rp, wp) until data_data_ok, so it is covered here.
    always_comb begin
        logic [PTR_W:0] off;
        logic [PTR_W:0] slot;
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off  = (PTR_W+1)'(i);
            slot = rp + off;
            if ((off < count) && (ent_addr[slot[PTR_W-1:0]] == ld_addr[31:2]))
                ld_conflict = 1'b1;
        end
    end
`else
    assign ld_conflict = !buf_empty;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: table-driven strobe vectors plus bus-order scoreboard.
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_addr;
    logic        ld_conflict, buf_empty;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .buf_empty(buf_empty),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

`ifdef STORE_BUF_ALIAS_CHECK_EN
    localparam logic ALIAS_FAR = 1'b0;
`else
    localparam logic ALIAS_FAR = 1'b1;
`endif

    typedef struct packed {
        logic [29:0] waddr;
        logic [1:0]  low2;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
    } beat_t;

    typedef struct {
        logic [3:0] strb;
        logic [1:0] size;
        logic [1:0] low2;
    } vec_t;

    beat_t      exp_q[$];
    vec_t       vt[10];
    logic [1:0] cur_size, cur_low2;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: record accepted beats, compare every bus cycle against the queue head.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (st_valid && st_ready) begin
                b = '{waddr: st_addr[31:2], low2: cur_low2, wdata: st_wdata, wstrb: st_wstrb, size: cur_size};
                exp_q.push_back(b);
            end
            if (data_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(data_req), 32'd0);
                end else begin
                    check("bus_addr",  data_addr,  {exp_q[0].waddr, exp_q[0].low2});
                    check("bus_wdata", data_wdata, exp_q[0].wdata);
                    check("bus_wstrb", 32'(data_wstrb), 32'(exp_q[0].wstrb));
                    check("bus_size",  32'(data_size),  32'(exp_q[0].size));
                    check("bus_wr",    32'(data_wr),    32'd1);
                    if (data_addr_ok) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_fields_zero",
                      32'(|{data_wr, data_size, data_addr, data_wstrb, data_wdata}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] sz, input logic [1:0] lo);
        st_valid = 1'b1; st_addr = a; st_wdata = d; st_wstrb = s;
        cur_size = sz; cur_low2 = lo;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] sz, input logic [1:0] lo);
        logic acc;
        drive_beat(a, d, s, sz, lo);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = st_ready;
            tick();
            if (acc) begin
                st_valid = 1'b0;
                return;
            end
        end
        check("push_timeout", 32'd0, 32'd1);
        st_valid = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (data_req) return;
            tick();
        end
        check("req_timeout", 32'(data_req), 32'd1);
    endtask

    task automatic serve_same();
        wait_req();
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    task automatic serve_delayed(input int a_dly, input int d_dly);
        wait_req();
        for (int i = 0; i < a_dly; i++) begin
            tick();
            check("delay_req_held", 32'(data_req), 32'd1);
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("wait_req_low", 32'(data_req), 32'd0);
        for (int i = 1; i < d_dly; i++) begin
            tick();
            check("wait_req_still_low", 32'(data_req), 32'd0);
            check("wait_not_empty", 32'(buf_empty), 32'd0);
        end
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_st_ready"},    32'(st_ready), 32'd1);
        check({tag, "_data_req"},    32'(data_req), 32'd0);
        check({tag, "_buf_empty"},   32'(buf_empty), 32'd1);
        check({tag, "_ld_conflict"}, 32'(ld_conflict), 32'd0);
        check({tag, "_bus_zero"},
              32'(|{data_wr, data_size, data_addr, data_wstrb, data_wdata}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'b0001, 2'd0, 2'd0};
        vt[1] = '{4'b0010, 2'd0, 2'd1};
        vt[2] = '{4'b0100, 2'd0, 2'd2};
        vt[3] = '{4'b1000, 2'd0, 2'd3};
        vt[4] = '{4'b0011, 2'd1, 2'd0};
        vt[5] = '{4'b1100, 2'd1, 2'd2};
        vt[6] = '{4'b0111, 2'd2, 2'd0};
        vt[7] = '{4'b1110, 2'd2, 2'd1};
        vt[8] = '{4'b1111, 2'd2, 2'd0};
        vt[9] = '{4'b0110, 2'd1, 2'd1};

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_wstrb = '0;
        ld_addr = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; cur_size = '0; cur_low2 = '0;
        #1;
        check_reset_outputs("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // Single SB: request appears two cycles after the push is driven.
        drive_beat(32'h1000_0003, 32'hAB00_0000, 4'b1000, 2'd0, 2'd3);
        tick();
        st_valid = 1'b0;
        check("sb_req_cycle1", 32'(data_req), 32'd0);
        check("sb_not_empty", 32'(buf_empty), 32'd0);
        tick();
        check("sb_req_cycle2", 32'(data_req), 32'd1);
        check("sb_addr", data_addr, 32'h1000_0003);
        check("sb_size", 32'(data_size), 32'd0);
        check("sb_wstrb", 32'(data_wstrb), 32'h8);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        check("sb_empty_after", 32'(buf_empty), 32'd1);

        // Strobe table: size and low2 checked by the scoreboard; address low bits are ignored.
        for (int i = 0; i < 10; i++) begin
            push(32'h3000_0002 + 32'(i) * 32'h10, $urandom, vt[i].strb, vt[i].size, vt[i].low2);
            serve_same();
            check("vec_empty", 32'(buf_empty), 32'd1);
        end

        // Fill: fifth beat waits for the first data_ok.
        for (int i = 0; i < 4; i++)
            push(32'h4000_0000 + 32'(i) * 4, $urandom, 4'b1111, 2'd2, 2'd0);
        check("fill_ready_low", 32'(st_ready), 32'd0);
        drive_beat(32'h4000_0010, 32'h5555_AAAA, 4'b0011, 2'd1, 2'd0);
        tick();
        check("fill_hold_ready", 32'(st_ready), 32'd0);
        wait_req();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("fill_wait_ready", 32'(st_ready), 32'd0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        check("fill_ready_after_pop", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        check("fill_full_again", 32'(st_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            serve_same();
            if (i < 3) check("b2b_req", 32'(data_req), 32'd1);
        end
        check("fill_drained", 32'(buf_empty), 32'd1);

        // Delayed handshake, then push and pop in the same cycle.
        push(32'h5000_0000, 32'h1234_5678, 4'b1111, 2'd2, 2'd0);
        serve_delayed(3, 4);
        check("delayed_empty", 32'(buf_empty), 32'd1);
        push(32'h5000_0004, 32'h0BAD_F00D, 4'b1111, 2'd2, 2'd0);
        wait_req();
        drive_beat(32'h5000_0008, 32'hCAFE_0001, 4'b0001, 2'd0, 2'd0);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        st_valid = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        check("pushpop_req", 32'(data_req), 32'd1);
        check("pushpop_ready", 32'(st_ready), 32'd1);
        for (int i = 0; i < 3; i++)
            push(32'h5000_0010 + 32'(i) * 4, $urandom, 4'b1100, 2'd1, 2'd2);
        check("pushpop_count_full", 32'(st_ready), 32'd0);
        for (int i = 0; i < 4; i++) serve_same();
        check("pushpop_drained", 32'(buf_empty), 32'd1);

        // Load alias against pending and in-flight store.
        push(32'h2000_0004, 32'hDEAD_BEEF, 4'b1111, 2'd2, 2'd0);
        wait_req();
        ld_addr = 32'h2000_0006; #1;
        check("alias_pending_same", 32'(ld_conflict), 32'd1);
        ld_addr = 32'h2000_0008; #1;
        check("alias_pending_other", 32'(ld_conflict), 32'(ALIAS_FAR));
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        ld_addr = 32'h2000_0006; #1;
        check("alias_inflight_same", 32'(ld_conflict), 32'd1);
        ld_addr = 32'h2000_0008; #1;
        check("alias_inflight_other", 32'(ld_conflict), 32'(ALIAS_FAR));
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        ld_addr = 32'h2000_0006; #1;
        check("alias_after_done", 32'(ld_conflict), 32'd0);
        ld_addr = '0;

        // Reset in WAIT with three entries queued; late responses must be ignored.
        for (int i = 0; i < 3; i++)
            push(32'h6000_0000 + 32'(i) * 4, $urandom, 4'b1111, 2'd2, 2'd0);
        wait_req();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("pre_reset_wait", 32'(data_req), 32'd0);
        check("pre_reset_busy", 32'(buf_empty), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        check_reset_outputs("late_ok");
        tick();
        check_reset_outputs("late_ok2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
